// File: rtl/prob_decode_if.sv
// Handshake bundle between a stochastic bitstream source / result consumer and prob_decode.
// The master drives samples and est_ready; the slave (the decoder) returns the registered result.
interface prob_decode_if #(
    parameter int N = 7
);
    logic         start;
    logic         bit_valid;
    logic         bit_in;
    logic         est_ready;
    logic [N-1:0] estimate;
    logic         saturated;
    logic         est_valid;
    logic         busy;

    modport master (
        output start, bit_valid, bit_in, est_ready,
        input  estimate, saturated, est_valid, busy
    );

    modport slave (
        input  start, bit_valid, bit_in, est_ready,
        output estimate, saturated, est_valid, busy
    );
endinterface

// File: rtl/prob_decode.sv
// Stochastic-to-binary converter: counts ones over a 2^N-sample window and holds the
// N-bit probability estimate under a valid/ready handshake until it is consumed.
module prob_decode #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    prob_decode_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [N:0] WIN  = {1'b1, {N{1'b0}}};
    localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};

    state_t       state;
    logic [N:0]   sample_cnt;
    logic [N:0]   ones_cnt;
    logic [N:0]   ones_next;
    logic         last_sample;
    logic [N-1:0] estimate_r;
    logic         saturated_r;
    logic         est_valid_r;
    logic         busy_r;

    // Count including this cycle's sample, so the result can be registered on the final sample.
    always_comb begin
        ones_next   = ones_cnt + {{N{1'b0}}, bus.bit_in};
        last_sample = (sample_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            ones_cnt    <= '0;
            estimate_r  <= '0;
            saturated_r <= 1'b0;
            est_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                        busy_r     <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.bit_valid) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        ones_cnt   <= ones_next;
                        if (last_sample) begin
                            state       <= HOLD;
                            busy_r      <= 1'b0;
                            est_valid_r <= 1'b1;
                            saturated_r <= (ones_next == WIN);
                            estimate_r  <= (ones_next == WIN) ? {N{1'b1}} : ones_next[N-1:0];
                        end
                    end
                end
                HOLD: begin
                    // start only counts when paired with the consuming handshake.
                    if (bus.est_ready) begin
                        est_valid_r <= 1'b0;
                        if (bus.start) begin
                            sample_cnt <= '0;
                            ones_cnt   <= '0;
                            busy_r     <= 1'b1;
                            state      <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_r      <= 1'b0;
                    est_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.estimate  = estimate_r;
    assign bus.saturated = saturated_r;
    assign bus.est_valid = est_valid_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_prob_decode.sv
// Self-checking bench for prob_decode (N = 7): randomized windows checked against a
// ones-count model, plus reset, bubbles, backpressure and back-to-back scenarios.
module tb_prob_decode;
    localparam int N   = 7;
    localparam int WIN = 1 << N;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic stim [WIN];

    always #5 clk = ~clk;

    prob_decode_if #(.N(N)) bus ();

    prob_decode #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Drive the stim window, with up to gap_max idle cycles before each valid sample.
    task automatic feed(input int gap_max);
        for (int i = 0; i < WIN; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max)) begin
                    bus.bit_valid = 1'b0;
                    bus.bit_in    = 1'($urandom);
                    step();
                end
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = stim[i];
            step();
        end
        bus.bit_valid = 1'b0;
    endtask

    function automatic int model_ones();
        int c = 0;
        for (int i = 0; i < WIN; i++) c += int'(stim[i]);
        return c;
    endfunction

    function automatic int model_estimate();
        int c = model_ones();
        return (c >= WIN) ? WIN - 1 : c;
    endfunction

    task automatic randomize_stim();
        for (int i = 0; i < WIN; i++) stim[i] = 1'($urandom);
    endtask

    task automatic test_reset();
        int exp_est;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.busy, bus.est_valid, bus.saturated, bus.estimate} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_initial: got %b expected 0", {bus.busy, bus.est_valid, bus.saturated, bus.estimate});
        end
        do_start();
        for (int i = 0; i < 20; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        bus.bit_valid = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.est_valid, bus.saturated, bus.estimate} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_accum: got %b expected 0", {bus.busy, bus.est_valid, bus.saturated, bus.estimate});
        end
        for (int i = 0; i < 5; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
            n_cmp++;
            if ({bus.busy, bus.est_valid} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL idle_pulse: busy/valid got %b expected 00", {bus.busy, bus.est_valid});
            end
        end
        bus.bit_valid = 1'b0;
        // A full window after reset confirms no stale counts survived.
        randomize_stim();
        exp_est = model_estimate();
        do_start();
        feed(0);
        n_cmp++;
        if ({bus.est_valid, bus.estimate} !== {1'b1, N'(exp_est)}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_window: got valid=%b est=%0d expected valid=1 est=%0d", bus.est_valid, bus.estimate, exp_est);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < WIN; i++) stim[i] = 1'b1;
        do_start();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_to_busy: got %b expected 1", bus.busy);
        end
        for (int i = 0; i < WIN - 1; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
        end
        n_cmp++;
        if ({bus.busy, bus.est_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL before_last_sample: busy/valid got %b expected 10", {bus.busy, bus.est_valid});
        end
        step();
        bus.bit_valid = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.est_valid, bus.saturated, bus.estimate} !== {1'b0, 1'b1, 1'b1, N'(WIN - 1)}) begin
            n_fail++;
            $display("[TB] FAIL all_ones: got busy=%b valid=%b sat=%b est=%0d expected 0 1 1 %0d", bus.busy, bus.est_valid, bus.saturated, bus.estimate, WIN - 1);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
        n_cmp++;
        if ({bus.est_valid, bus.busy, bus.saturated, bus.estimate} !== {1'b0, 1'b0, 1'b1, N'(WIN - 1)}) begin
            n_fail++;
            $display("[TB] FAIL consume_all_ones: got valid=%b busy=%b sat=%b est=%0d expected 0 0 1 %0d", bus.est_valid, bus.busy, bus.saturated, bus.estimate, WIN - 1);
        end
    endtask

    task automatic test_closed_loop(input int prob);
        int perm [WIN];
        int j;
        int t;
        for (int i = 0; i < WIN; i++) perm[i] = i;
        for (int i = WIN - 1; i > 0; i--) begin
            j       = int'($urandom_range(i));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < WIN; i++) stim[i] = (perm[i] < prob);
        // A sample offered alongside start must not be counted.
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        do_start();
        feed(0);
        n_cmp++;
        if ({bus.est_valid, bus.saturated, bus.estimate} !== {1'b1, 1'b0, N'(prob)}) begin
            n_fail++;
            $display("[TB] FAIL closed_loop_p%0d: got valid=%b sat=%b est=%0d expected 1 0 %0d", prob, bus.est_valid, bus.saturated, bus.estimate, prob);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    task automatic test_bubbles();
        int cycles = 0;
        for (int i = 0; i < WIN; i++) stim[i] = (i % 2 == 0);
        do_start();
        for (int i = 0; i < WIN; i++) begin
            repeat ($urandom_range(3)) begin
                bus.bit_valid = 1'b0;
                bus.bit_in    = 1'($urandom);
                step();
                cycles++;
                n_cmp++;
                if ({bus.busy, bus.est_valid} !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL bubble_busy: sample %0d busy/valid got %b expected 10", i, {bus.busy, bus.est_valid});
                end
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = stim[i];
            step();
            cycles++;
            if (i < WIN - 1) begin
                n_cmp++;
                if ({bus.busy, bus.est_valid} !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL bubble_accum: sample %0d busy/valid got %b expected 10", i, {bus.busy, bus.est_valid});
                end
            end
        end
        bus.bit_valid = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.est_valid, bus.saturated, bus.estimate} !== {1'b0, 1'b1, 1'b0, N'(model_estimate())}) begin
            n_fail++;
            $display("[TB] FAIL bubbles_result: got busy=%b valid=%b sat=%b est=%0d expected 0 1 0 %0d (cycles %0d)", bus.busy, bus.est_valid, bus.saturated, bus.estimate, model_estimate(), cycles);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int exp_est;
        logic exp_sat;
        randomize_stim();
        exp_est = model_estimate();
        exp_sat = (model_ones() == WIN);
        do_start();
        feed(0);
        for (int i = 0; i < 10; i++) begin
            bus.est_ready = 1'b0;
            bus.start     = 1'($urandom);
            bus.bit_valid = 1'($urandom);
            bus.bit_in    = 1'($urandom);
            step();
            n_cmp++;
            if ({bus.est_valid, bus.busy, bus.saturated, bus.estimate} !== {1'b1, 1'b0, exp_sat, N'(exp_est)}) begin
                n_fail++;
                $display("[TB] FAIL hold_stable: cycle %0d got valid=%b busy=%b sat=%b est=%0d expected 1 0 %b %0d", i, bus.est_valid, bus.busy, bus.saturated, bus.estimate, exp_sat, exp_est);
            end
        end
        bus.est_ready = 1'b1;
        bus.start     = 1'b1;
        bus.bit_valid = 1'b0;
        step();
        bus.est_ready = 1'b0;
        bus.start     = 1'b0;
        n_cmp++;
        if ({bus.est_valid, bus.busy, bus.estimate} !== {1'b0, 1'b1, N'(exp_est)}) begin
            n_fail++;
            $display("[TB] FAIL chain_start: got valid=%b busy=%b est=%0d expected 0 1 %0d", bus.est_valid, bus.busy, bus.estimate, exp_est);
        end
        for (int i = 0; i < WIN; i++) stim[i] = 1'b0;
        feed(2);
        n_cmp++;
        if ({bus.est_valid, bus.saturated, bus.estimate} !== {1'b1, 1'b0, N'(0)}) begin
            n_fail++;
            $display("[TB] FAIL chain_zeros: got valid=%b sat=%b est=%0d expected 1 0 0", bus.est_valid, bus.saturated, bus.estimate);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int exp_est;
        bus.start     = 1'b1;
        bus.est_ready = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            randomize_stim();
            exp_est = model_estimate();
            feed(0);
            n_cmp++;
            if ({bus.est_valid, bus.busy, bus.estimate} !== {1'b1, 1'b0, N'(exp_est)}) begin
                n_fail++;
                $display("[TB] FAIL b2b_result: window %0d got valid=%b busy=%b est=%0d expected 1 0 %0d", w, bus.est_valid, bus.busy, bus.estimate, exp_est);
            end
            if (w == 2) bus.start = 1'b0;
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
            n_cmp++;
            if ({bus.est_valid, bus.busy} !== {1'b0, (w != 2)}) begin
                n_fail++;
                $display("[TB] FAIL b2b_handshake: window %0d got valid/busy %b expected %b", w, {bus.est_valid, bus.busy}, {1'b0, (w != 2)});
            end
        end
        bus.est_ready = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic test_mid_window_reset();
        int perm [WIN];
        int j;
        int t;
        do_start();
        for (int i = 0; i < 50; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.est_valid, bus.busy} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL abort_no_result: got valid/busy %b expected 00", {bus.est_valid, bus.busy});
            end
        end
        for (int i = 0; i < WIN; i++) perm[i] = i;
        for (int i = WIN - 1; i > 0; i--) begin
            j       = int'($urandom_range(i));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < WIN; i++) stim[i] = (perm[i] < 10);
        do_start();
        feed(1);
        n_cmp++;
        if ({bus.est_valid, bus.saturated, bus.estimate} !== {1'b1, 1'b0, N'(10)}) begin
            n_fail++;
            $display("[TB] FAIL after_abort: got valid=%b sat=%b est=%0d expected 1 0 10", bus.est_valid, bus.saturated, bus.estimate);
        end
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.est_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_closed_loop(32);
        test_closed_loop(0);
        test_closed_loop(127);
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_mid_window_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
